urv_writeback: RTL and testbench

URV_WRITEBACK -- requirements
Module: urv_writeback

---
 rtl/urv_defs_pkg.sv | 33 +++
 rtl/urv_load_align.sv | 37 +++
 rtl/urv_writeback.sv | 216 +++++++++++++++++++++
 tb/tb_urv_writeback.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/urv_defs_pkg.sv
// Shared definitions for the writeback stage: result-source codes,
// load/store function codes and the writeback FSM state encoding.
package urv_defs_pkg;

  // Selects which execute-stage result feeds a non-memory register write.
  typedef enum logic [1:0] {
    RD_SOURCE_ALU      = 2'd0,
    RD_SOURCE_SHIFTER  = 2'd1,
    RD_SOURCE_MULTIPLY = 2'd2,
    RD_SOURCE_CSR      = 2'd3
  } rd_source_t;

  // Load width/sign codes (RISC-V funct3 encoding).
  localparam logic [2:0] FUNC_LB  = 3'b000;
  localparam logic [2:0] FUNC_LH  = 3'b001;
  localparam logic [2:0] FUNC_LW  = 3'b010;
  localparam logic [2:0] FUNC_LBU = 3'b100;
  localparam logic [2:0] FUNC_LHU = 3'b101;

  // Store width codes (RISC-V funct3 encoding).
  localparam logic [2:0] FUNC_SB  = 3'b000;
  localparam logic [2:0] FUNC_SH  = 3'b001;
  localparam logic [2:0] FUNC_SW  = 3'b010;

  // Writeback FSM: IDLE accepts instructions, WAIT_MEM waits for the data
  // memory, HOLD keeps captured load data while the pipeline is stalled.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    HOLD     = 2'd2
  } wb_state_t;

endpackage

// File: rtl/urv_load_align.sv
// Extracts the addressed byte/halfword from a 32-bit load word and
// sign- or zero-extends it according to the load function code.
module urv_load_align
  import urv_defs_pkg::*;
(
  input  logic [2:0]  fun_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Lane selection followed by width/sign extension.
  always_comb begin
    byte_lane = data_i[7:0];
    case (addr_i)
      2'd0: byte_lane = data_i[7:0];
      2'd1: byte_lane = data_i[15:8];
      2'd2: byte_lane = data_i[23:16];
      2'd3: byte_lane = data_i[31:24];
      default: byte_lane = data_i[7:0];
    endcase
    half_lane = addr_i[1] ? data_i[31:16] : data_i[15:0];

    data_o = data_i;
    case (fun_i)
      FUNC_LB:  data_o = {{24{byte_lane[7]}}, byte_lane};
      FUNC_LBU: data_o = {24'h000000, byte_lane};
      FUNC_LH:  data_o = {{16{half_lane[15]}}, half_lane};
      FUNC_LHU: data_o = {16'h0000, half_lane};
      default:  data_o = data_i;
    endcase
  end

endmodule

// File: rtl/urv_writeback.sv
// Writeback stage: selects the result of an accepted instruction, waits for
// data memory on loads/stores (with a bus-error timeout), and drives the
// register-file write port plus a one-cycle-delayed bypass copy of it.
//
// Handshake: an instruction is taken only in a cycle where x_valid_i=1 and
// w_stall_i=0; dm_*_done_i are single-cycle completion strobes that only
// count while an access is outstanding (same-cycle in IDLE, or in WAIT_MEM).
module urv_writeback
  import urv_defs_pkg::*;
#(
  parameter int g_timeout = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        w_stall_i,
  input  logic        x_valid_i,
  input  logic        x_load_i,
  input  logic        x_store_i,
  input  logic        x_rd_write_i,
  input  logic [2:0]  x_fun_i,
  input  logic [4:0]  x_rd_i,
  input  logic [1:0]  x_rd_source_i,
  input  logic [31:0] x_rd_value_i,
  input  logic [31:0] x_rd_shifter_i,
  input  logic [31:0] x_rd_multiply_i,
  input  logic [31:0] x_dm_addr_i,
  input  logic [31:0] dm_data_l_i,
  input  logic        dm_load_done_i,
  input  logic        dm_store_done_i,
  output logic [4:0]  rf_rd_o,
  output logic [31:0] rf_rd_value_o,
  output logic        rf_rd_write_o,
  output logic        w_stall_req_o,
  output logic        w_bus_error_o,
  output logic [4:0]  w_bypass_rd_o,
  output logic [31:0] w_bypass_value_o,
  output logic        w_bypass_write_o,
  output wb_state_t   dbg_state_o
);

  // Last counter value of a wait; reaching it without done is a bus error.
  localparam logic [7:0] TIMEOUT_LAST = 8'(g_timeout - 1);

  wb_state_t   state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] cap_q, cap_d;
  logic        latch_en;

  // Access parameters held while the memory access is outstanding.
  logic [2:0]  p_fun_q;
  logic [4:0]  p_rd_q;
  logic        p_rd_write_q;
  logic [1:0]  p_addr_q;
  logic        p_load_q;

  logic        accept;
  logic        is_mem;
  logic        done_now;
  logic        p_done;
  logic [31:0] alu_result;
  logic [2:0]  align_fun;
  logic [1:0]  align_addr;
  logic [31:0] align_data;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^x_dm_addr_i[31:2];

  assign accept   = x_valid_i & ~w_stall_i;
  assign is_mem   = x_load_i | x_store_i;
  assign done_now = (x_load_i & dm_load_done_i) | (x_store_i & dm_store_done_i);
  assign p_done   = p_load_q ? dm_load_done_i : dm_store_done_i;

  // Non-memory result selection.
  always_comb begin
    case (rd_source_t'(x_rd_source_i))
      RD_SOURCE_SHIFTER:  alu_result = x_rd_shifter_i;
      RD_SOURCE_MULTIPLY: alu_result = x_rd_multiply_i;
      default:            alu_result = x_rd_value_i;
    endcase
  end

  // Align using the live instruction in IDLE, the latched access otherwise.
  always_comb begin
    align_fun  = x_fun_i;
    align_addr = x_dm_addr_i[1:0];
    if (state_q != IDLE) begin
      align_fun  = p_fun_q;
      align_addr = p_addr_q;
    end
  end

  urv_load_align u_load_align (
    .fun_i  (align_fun),
    .addr_i (align_addr),
    .data_i (dm_data_l_i),
    .data_o (align_data)
  );

  // Next-state, timeout counter and register-file write decisions.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    cap_d         = cap_q;
    latch_en      = 1'b0;
    rf_rd_write_o = 1'b0;
    rf_rd_o       = 5'd0;
    rf_rd_value_o = 32'd0;
    w_stall_req_o = 1'b0;
    w_bus_error_o = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_mem) begin
            if (done_now) begin
              if (x_load_i && x_rd_write_i && (x_rd_i != 5'd0)) begin
                rf_rd_write_o = 1'b1;
                rf_rd_o       = x_rd_i;
                rf_rd_value_o = align_data;
              end
            end else begin
              latch_en = 1'b1;
              cnt_d    = 8'd0;
              state_d  = WAIT_MEM;
            end
          end else if (x_rd_write_i && (x_rd_i != 5'd0)) begin
            rf_rd_write_o = 1'b1;
            rf_rd_o       = x_rd_i;
            rf_rd_value_o = alu_result;
          end
        end
      end

      WAIT_MEM: begin
        w_stall_req_o = 1'b1;
        if (p_done) begin
          if (!w_stall_i) begin
            if (p_load_q && p_rd_write_q && (p_rd_q != 5'd0)) begin
              rf_rd_write_o = 1'b1;
              rf_rd_o       = p_rd_q;
              rf_rd_value_o = align_data;
            end
            state_d = IDLE;
          end else begin
            cap_d   = align_data;
            state_d = HOLD;
          end
        end else if (cnt_q == TIMEOUT_LAST) begin
          w_bus_error_o = 1'b1;
          state_d       = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      HOLD: begin
        if (!w_stall_i) begin
          if (p_load_q && p_rd_write_q && (p_rd_q != 5'd0)) begin
            rf_rd_write_o = 1'b1;
            rf_rd_o       = p_rd_q;
            rf_rd_value_o = cap_q;
          end
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // FSM state, timeout counter and captured load data.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      cap_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cap_q   <= cap_d;
    end
  end

  // Latch the outstanding access when leaving IDLE for WAIT_MEM.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      p_fun_q      <= 3'd0;
      p_rd_q       <= 5'd0;
      p_rd_write_q <= 1'b0;
      p_addr_q     <= 2'd0;
      p_load_q     <= 1'b0;
    end else if (latch_en) begin
      p_fun_q      <= x_fun_i;
      p_rd_q       <= x_rd_i;
      p_rd_write_q <= x_rd_write_i;
      p_addr_q     <= x_dm_addr_i[1:0];
      p_load_q     <= x_load_i;
    end
  end

  // Bypass copy of the register-file write port, one cycle later.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      w_bypass_rd_o    <= 5'd0;
      w_bypass_value_o <= 32'd0;
      w_bypass_write_o <= 1'b0;
    end else begin
      w_bypass_rd_o    <= rf_rd_o;
      w_bypass_value_o <= rf_rd_value_o;
      w_bypass_write_o <= rf_rd_write_o;
    end
  end

  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_urv_writeback.sv
// Directed bench for urv_writeback: a table of single-cycle vectors followed
// by hand-written multi-cycle sequences (wait, hold, timeout, reset).
module tb_urv_writeback;
  import urv_defs_pkg::*;

  localparam int TIMEOUT = 4;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        w_stall_i, x_valid_i, x_load_i, x_store_i, x_rd_write_i;
  logic [2:0]  x_fun_i;
  logic [4:0]  x_rd_i;
  logic [1:0]  x_rd_source_i;
  logic [31:0] x_rd_value_i, x_rd_shifter_i, x_rd_multiply_i, x_dm_addr_i;
  logic [31:0] dm_data_l_i;
  logic        dm_load_done_i, dm_store_done_i;
  logic [4:0]  rf_rd_o, w_bypass_rd_o;
  logic [31:0] rf_rd_value_o, w_bypass_value_o;
  logic        rf_rd_write_o, w_stall_req_o, w_bus_error_o, w_bypass_write_o;
  wb_state_t   dbg_state_o;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic        valid, stall, load, store, rd_write;
    logic [2:0]  fun;
    logic [4:0]  rd;
    logic [1:0]  src;
    logic [31:0] value, shifter, mult, addr, data;
    logic        load_done, store_done;
    logic        exp_write;
    logic [4:0]  exp_rd;
    logic [31:0] exp_value;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs[NV];

  urv_writeback #(.g_timeout(TIMEOUT)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .w_stall_i        (w_stall_i),
    .x_valid_i        (x_valid_i),
    .x_load_i         (x_load_i),
    .x_store_i        (x_store_i),
    .x_rd_write_i     (x_rd_write_i),
    .x_fun_i          (x_fun_i),
    .x_rd_i           (x_rd_i),
    .x_rd_source_i    (x_rd_source_i),
    .x_rd_value_i     (x_rd_value_i),
    .x_rd_shifter_i   (x_rd_shifter_i),
    .x_rd_multiply_i  (x_rd_multiply_i),
    .x_dm_addr_i      (x_dm_addr_i),
    .dm_data_l_i      (dm_data_l_i),
    .dm_load_done_i   (dm_load_done_i),
    .dm_store_done_i  (dm_store_done_i),
    .rf_rd_o          (rf_rd_o),
    .rf_rd_value_o    (rf_rd_value_o),
    .rf_rd_write_o    (rf_rd_write_o),
    .w_stall_req_o    (w_stall_req_o),
    .w_bus_error_o    (w_bus_error_o),
    .w_bypass_rd_o    (w_bypass_rd_o),
    .w_bypass_value_o (w_bypass_value_o),
    .w_bypass_write_o (w_bypass_write_o),
    .dbg_state_o      (dbg_state_o)
  );

  // Clock and watchdog.
  always #5 clk_i = ~clk_i;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    w_stall_i       = 1'b0;
    x_valid_i       = 1'b0;
    x_load_i        = 1'b0;
    x_store_i       = 1'b0;
    x_rd_write_i    = 1'b0;
    x_fun_i         = 3'd0;
    x_rd_i          = 5'd0;
    x_rd_source_i   = 2'd0;
    x_rd_value_i    = 32'h11111111;
    x_rd_shifter_i  = 32'h22222222;
    x_rd_multiply_i = 32'h33333333;
    x_dm_addr_i     = 32'd0;
    dm_data_l_i     = 32'd0;
    dm_load_done_i  = 1'b0;
    dm_store_done_i = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Present a load that does not complete in its accept cycle.
  task automatic start_load(input logic [2:0] fun, input logic [4:0] rd, input logic [31:0] addr);
    idle_inputs();
    x_valid_i    = 1'b1;
    x_load_i     = 1'b1;
    x_rd_write_i = 1'b1;
    x_fun_i      = fun;
    x_rd_i       = rd;
    x_dm_addr_i  = addr;
  endtask

  initial begin
    vecs[0]  = '{1,0,0,0,1, 3'd0,     5'd5,  2'd0, 32'h12345678, 32'h22222222, 32'h33333333, 32'h0,        32'h0,        0,0, 1, 5'd5,  32'h12345678};
    vecs[1]  = '{1,0,0,0,1, 3'd0,     5'd7,  2'd1, 32'h11111111, 32'hAAAA0000, 32'h33333333, 32'h0,        32'h0,        0,0, 1, 5'd7,  32'hAAAA0000};
    vecs[2]  = '{1,0,0,0,1, 3'd0,     5'd31, 2'd2, 32'h11111111, 32'h22222222, 32'h0BADF00D, 32'h0,        32'h0,        0,0, 1, 5'd31, 32'h0BADF00D};
    vecs[3]  = '{1,0,0,0,1, 3'd0,     5'd1,  2'd3, 32'hCAFEBABE, 32'h22222222, 32'h33333333, 32'h0,        32'h0,        0,0, 1, 5'd1,  32'hCAFEBABE};
    vecs[4]  = '{1,0,0,0,1, 3'd0,     5'd0,  2'd0, 32'h44444444, 32'h22222222, 32'h33333333, 32'h0,        32'h0,        0,0, 0, 5'd0,  32'h0};
    vecs[5]  = '{0,0,0,0,1, 3'd0,     5'd6,  2'd0, 32'h55555555, 32'h22222222, 32'h33333333, 32'h0,        32'h0,        0,0, 0, 5'd0,  32'h0};
    vecs[6]  = '{1,1,0,0,1, 3'd0,     5'd6,  2'd0, 32'h66666666, 32'h22222222, 32'h33333333, 32'h0,        32'h0,        0,0, 0, 5'd0,  32'h0};
    vecs[7]  = '{1,0,0,0,0, 3'd0,     5'd6,  2'd0, 32'h77777777, 32'h22222222, 32'h33333333, 32'h0,        32'h0,        0,0, 0, 5'd0,  32'h0};
    vecs[8]  = '{1,0,1,0,1, FUNC_LB,  5'd10, 2'd0, 32'h11111111, 32'h22222222, 32'h33333333, 32'h00000003, 32'h80FFFFFF, 1,0, 1, 5'd10, 32'hFFFFFF80};
    vecs[9]  = '{1,0,1,0,1, FUNC_LHU, 5'd11, 2'd0, 32'h11111111, 32'h22222222, 32'h33333333, 32'h10000002, 32'h80010000, 1,0, 1, 5'd11, 32'h00008001};
    vecs[10] = '{1,0,1,0,1, FUNC_LBU, 5'd12, 2'd0, 32'h11111111, 32'h22222222, 32'h33333333, 32'h00000001, 32'h12345678, 1,0, 1, 5'd12, 32'h00000056};
    vecs[11] = '{1,0,1,0,1, FUNC_LH,  5'd13, 2'd0, 32'h11111111, 32'h22222222, 32'h33333333, 32'h00000000, 32'h12348765, 1,0, 1, 5'd13, 32'hFFFF8765};
    vecs[12] = '{1,0,1,0,1, FUNC_LW,  5'd14, 2'd0, 32'h11111111, 32'h22222222, 32'h33333333, 32'h00000004, 32'hDEADBEEF, 1,0, 1, 5'd14, 32'hDEADBEEF};
    vecs[13] = '{1,0,1,0,1, FUNC_LB,  5'd15, 2'd0, 32'h11111111, 32'h22222222, 32'h33333333, 32'h00000000, 32'h0000007F, 1,0, 1, 5'd15, 32'h0000007F};
    vecs[14] = '{1,0,0,1,1, FUNC_SW,  5'd16, 2'd0, 32'h11111111, 32'h22222222, 32'h33333333, 32'h00000008, 32'h0,        0,1, 0, 5'd0,  32'h0};
    vecs[15] = '{0,0,0,0,0, 3'd0,     5'd0,  2'd0, 32'h11111111, 32'h22222222, 32'h33333333, 32'h0,        32'h99999999, 1,1, 0, 5'd0,  32'h0};
    vecs[16] = '{1,0,1,0,1, FUNC_LH,  5'd17, 2'd0, 32'h11111111, 32'h22222222, 32'h33333333, 32'h00000002, 32'h7FFF0000, 1,0, 1, 5'd17, 32'h00007FFF};
    vecs[17] = '{1,0,1,0,1, FUNC_LB,  5'd18, 2'd0, 32'h11111111, 32'h22222222, 32'h33333333, 32'h00000002, 32'h00FE0000, 1,0, 1, 5'd18, 32'hFFFFFFFE};

    // Reset state.
    idle_inputs();
    @(negedge clk_i);
    check("rst_state",      32'(dbg_state_o), 32'(IDLE));
    check("rst_rf_write",   32'(rf_rd_write_o), 32'd0);
    check("rst_rf_rd",      32'(rf_rd_o), 32'd0);
    check("rst_rf_value",   rf_rd_value_o, 32'd0);
    check("rst_stall_req",  32'(w_stall_req_o), 32'd0);
    check("rst_bus_error",  32'(w_bus_error_o), 32'd0);
    check("rst_byp_write",  32'(w_bypass_write_o), 32'd0);
    check("rst_byp_rd",     32'(w_bypass_rd_o), 32'd0);
    check("rst_byp_value",  w_bypass_value_o, 32'd0);
    tick();
    rst_i = 1'b0;
    tick();

    // Single-cycle table: write port in the accept cycle, bypass one cycle later.
    for (int i = 0; i < NV; i++) begin
      idle_inputs();
      w_stall_i       = vecs[i].stall;
      x_valid_i       = vecs[i].valid;
      x_load_i        = vecs[i].load;
      x_store_i       = vecs[i].store;
      x_rd_write_i    = vecs[i].rd_write;
      x_fun_i         = vecs[i].fun;
      x_rd_i          = vecs[i].rd;
      x_rd_source_i   = vecs[i].src;
      x_rd_value_i    = vecs[i].value;
      x_rd_shifter_i  = vecs[i].shifter;
      x_rd_multiply_i = vecs[i].mult;
      x_dm_addr_i     = vecs[i].addr;
      dm_data_l_i     = vecs[i].data;
      dm_load_done_i  = vecs[i].load_done;
      dm_store_done_i = vecs[i].store_done;
      @(negedge clk_i);
      check($sformatf("v%0d_rf_write", i), 32'(rf_rd_write_o), 32'(vecs[i].exp_write));
      check($sformatf("v%0d_rf_rd", i),    32'(rf_rd_o), 32'(vecs[i].exp_rd));
      check($sformatf("v%0d_rf_value", i), rf_rd_value_o, vecs[i].exp_value);
      check($sformatf("v%0d_stall_req", i), 32'(w_stall_req_o), 32'd0);
      tick();
      idle_inputs();
      check($sformatf("v%0d_state", i),     32'(dbg_state_o), 32'(IDLE));
      check($sformatf("v%0d_byp_write", i), 32'(w_bypass_write_o), 32'(vecs[i].exp_write));
      check($sformatf("v%0d_byp_rd", i),    32'(w_bypass_rd_o), 32'(vecs[i].exp_rd));
      check($sformatf("v%0d_byp_value", i), w_bypass_value_o, vecs[i].exp_value);
    end

    // Load completing three cycles after acceptance.
    start_load(FUNC_LW, 5'd9, 32'h00000100);
    @(negedge clk_i);
    check("wait_acc_write", 32'(rf_rd_write_o), 32'd0);
    check("wait_acc_stall", 32'(w_stall_req_o), 32'd0);
    tick();
    idle_inputs();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk_i);
      check($sformatf("wait_c%0d_stall", c), 32'(w_stall_req_o), 32'd1);
      check($sformatf("wait_c%0d_write", c), 32'(rf_rd_write_o), 32'd0);
      tick();
    end
    dm_data_l_i    = 32'h0F0F1234;
    dm_load_done_i = 1'b1;
    @(negedge clk_i);
    check("wait_done_stall", 32'(w_stall_req_o), 32'd1);
    check("wait_done_write", 32'(rf_rd_write_o), 32'd1);
    check("wait_done_rd",    32'(rf_rd_o), 32'd9);
    check("wait_done_value", rf_rd_value_o, 32'h0F0F1234);
    tick();
    idle_inputs();
    @(negedge clk_i);
    check("wait_after_state", 32'(dbg_state_o), 32'(IDLE));
    check("wait_after_stall", 32'(w_stall_req_o), 32'd0);
    check("wait_after_write", 32'(rf_rd_write_o), 32'd0);
    check("wait_after_byp",   w_bypass_value_o, 32'h0F0F1234);
    tick();

    // Done while the pipeline is stalled: capture, hold, write later.
    start_load(FUNC_LBU, 5'd12, 32'h00000102);
    @(negedge clk_i);
    check("hold_acc_write", 32'(rf_rd_write_o), 32'd0);
    tick();
    idle_inputs();
    w_stall_i      = 1'b1;
    dm_load_done_i = 1'b1;
    dm_data_l_i    = 32'h00AB0000;
    @(negedge clk_i);
    check("hold_done_stallreq", 32'(w_stall_req_o), 32'd1);
    check("hold_done_write",    32'(rf_rd_write_o), 32'd0);
    tick();
    check("hold_state", 32'(dbg_state_o), 32'(HOLD));
    dm_data_l_i = 32'hFFFFFFFF;
    @(negedge clk_i);
    check("hold_c1_stallreq", 32'(w_stall_req_o), 32'd0);
    check("hold_c1_write",    32'(rf_rd_write_o), 32'd0);
    tick();
    idle_inputs();
    @(negedge clk_i);
    check("hold_rel_write", 32'(rf_rd_write_o), 32'd1);
    check("hold_rel_rd",    32'(rf_rd_o), 32'd12);
    check("hold_rel_value", rf_rd_value_o, 32'h000000AB);
    tick();
    check("hold_end_state", 32'(dbg_state_o), 32'(IDLE));
    @(negedge clk_i);
    check("hold_end_write", 32'(rf_rd_write_o), 32'd0);
    check("hold_end_byp",   w_bypass_value_o, 32'h000000AB);
    tick();

    // Timeout with no done: one error pulse on the fourth wait cycle.
    start_load(FUNC_LW, 5'd3, 32'h00000200);
    @(negedge clk_i);
    tick();
    idle_inputs();
    for (int c = 0; c < TIMEOUT; c++) begin
      @(negedge clk_i);
      check($sformatf("tmo_c%0d_error", c), 32'(w_bus_error_o), (c == TIMEOUT - 1) ? 32'd1 : 32'd0);
      check($sformatf("tmo_c%0d_stall", c), 32'(w_stall_req_o), 32'd1);
      check($sformatf("tmo_c%0d_write", c), 32'(rf_rd_write_o), 32'd0);
      tick();
    end
    check("tmo_end_state", 32'(dbg_state_o), 32'(IDLE));
    @(negedge clk_i);
    check("tmo_end_error", 32'(w_bus_error_o), 32'd0);
    check("tmo_end_stall", 32'(w_stall_req_o), 32'd0);
    tick();

    // Done on the same cycle the timeout would fire: normal completion.
    start_load(FUNC_LW, 5'd4, 32'h00000300);
    @(negedge clk_i);
    tick();
    idle_inputs();
    for (int c = 0; c < TIMEOUT; c++) begin
      if (c == TIMEOUT - 1) begin
        dm_load_done_i = 1'b1;
        dm_data_l_i    = 32'h55AA55AA;
      end
      @(negedge clk_i);
      check($sformatf("race_c%0d_error", c), 32'(w_bus_error_o), 32'd0);
      check($sformatf("race_c%0d_write", c), 32'(rf_rd_write_o), (c == TIMEOUT - 1) ? 32'd1 : 32'd0);
      tick();
    end
    check("race_rd_byp",    32'(w_bypass_rd_o), 32'd4);
    check("race_value_byp", w_bypass_value_o, 32'h55AA55AA);
    check("race_state",     32'(dbg_state_o), 32'(IDLE));
    idle_inputs();

    // Reset in the middle of a wait abandons the access.
    start_load(FUNC_LW, 5'd8, 32'h00000400);
    @(negedge clk_i);
    tick();
    idle_inputs();
    @(negedge clk_i);
    check("rstw_pre_stall", 32'(w_stall_req_o), 32'd1);
    #1 rst_i = 1'b1;
    #1;
    check("rstw_state",     32'(dbg_state_o), 32'(IDLE));
    check("rstw_stall",     32'(w_stall_req_o), 32'd0);
    check("rstw_write",     32'(rf_rd_write_o), 32'd0);
    check("rstw_error",     32'(w_bus_error_o), 32'd0);
    check("rstw_byp_write", 32'(w_bypass_write_o), 32'd0);
    check("rstw_byp_value", w_bypass_value_o, 32'd0);
    tick();
    rst_i          = 1'b0;
    dm_load_done_i = 1'b1;
    dm_data_l_i    = 32'h12121212;
    @(negedge clk_i);
    check("rstw_late_write", 32'(rf_rd_write_o), 32'd0);
    check("rstw_late_stall", 32'(w_stall_req_o), 32'd0);
    tick();
    idle_inputs();
    @(negedge clk_i);
    check("rstw_end_error", 32'(w_bus_error_o), 32'd0);
    check("rstw_end_state", 32'(dbg_state_o), 32'(IDLE));
    check("rstw_end_byp",   32'(w_bypass_write_o), 32'd0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
